// File: rtl/aes_ahb_initiator_pkg.sv
// Shared constants and types for the AES AHB-Lite initiator.
// Address map of the AES slave and the job sequencer states.
package aes_ahb_pkg;

    localparam logic [31:0] ADDR_DATA   = 32'd100;
    localparam logic [31:0] ADDR_KEY    = 32'd200;
    localparam logic [31:0] ADDR_CTRL   = 32'd301;
    localparam logic [31:0] ADDR_COMMIT = 32'd401;
    localparam int          WAIT_CYCLES = 20;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    typedef enum logic [3:0] {
        IDLE,
        WR_DATA,
        COMMIT_DATA,
        WR_KEY,
        COMMIT_KEY,
        WR_CTRL,
        COMMIT_CTRL,
        WAIT,
        RD,
        DONE
    } state_t;

endpackage

// File: rtl/aes_ahb_initiator_if.sv
// AHB-Lite signal bundle between the initiator and the AES slave.
// Master drives address/control/write data; slave returns ready/read data.
interface aes_ahb_initiator_if;

    logic [31:0] HADDR;
    logic [31:0] HWDATA;
    logic        HWRITE;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic        HREADY;
    logic [31:0] HRDATA;

    modport master (
        output HADDR, HWDATA, HWRITE, HTRANS, HSIZE, HBURST,
        input  HREADY, HRDATA
    );

    modport slave (
        input  HADDR, HWDATA, HWRITE, HTRANS, HSIZE, HBURST,
        output HREADY, HRDATA
    );

endinterface

// File: rtl/aes_ahb_initiator.sv
// AHB-Lite master running one AES job: load data and key, commit,
// set enable/mode, wait, then read the 128-bit result back.
module aes_ahb_initiator
    import aes_ahb_pkg::*;
(
    input  logic         HCLK,
    input  logic         HRESET,
    input  logic         start,
    input  logic [127:0] data_in,
    input  logic [127:0] key_in,
    input  logic         encrypt_mode,
    output logic         busy,
    output logic [127:0] result,
    output logic         result_valid,
    aes_ahb_initiator_if.master bus
);

    localparam logic [7:0] WAIT_LAST = 8'(WAIT_CYCLES - 1);

    state_t          state, state_n;
    logic [1:0]      idx, idx_n;
    logic [7:0]      cnt, cnt_n;
    logic [3:0][31:0] data_r, key_r, shadow;
    logic            mode_r;
    logic [31:0]     hwdata_r, wdata_n, haddr_n;
    logic            hwrite_n;
    logic [1:0]      htrans_n;
    logic            rd_dp;
    logic [1:0]      rd_word;
    logic            accept;

    assign accept = (state == IDLE) && start && !busy;

    assign bus.HADDR  = haddr_n;
    assign bus.HTRANS = htrans_n;
    assign bus.HWRITE = hwrite_n;
    assign bus.HWDATA = hwdata_r;
    assign bus.HSIZE  = HSIZE_WORD;
    assign bus.HBURST = HBURST_SINGLE;

    // Sequencer state, word index and wait counter.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state <= IDLE;
            idx   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            cnt   <= cnt_n;
        end
    end

    // Next state and the current address phase; advances only on HREADY.
    always_comb begin
        state_n  = state;
        idx_n    = idx;
        cnt_n    = cnt;
        haddr_n  = '0;
        htrans_n = HTRANS_IDLE;
        hwrite_n = 1'b0;
        wdata_n  = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_n = WR_DATA;
                    idx_n   = '0;
                end
            end
            WR_DATA: begin
                haddr_n  = ADDR_DATA + {30'd0, idx};
                htrans_n = HTRANS_NONSEQ;
                hwrite_n = 1'b1;
                wdata_n  = data_r[~idx];
                if (bus.HREADY) begin
                    idx_n = idx + 2'd1;
                    if (idx == 2'd3) state_n = COMMIT_DATA;
                end
            end
            COMMIT_DATA: begin
                haddr_n  = ADDR_COMMIT;
                htrans_n = HTRANS_NONSEQ;
                hwrite_n = 1'b1;
                if (bus.HREADY) state_n = WR_KEY;
            end
            WR_KEY: begin
                haddr_n  = ADDR_KEY + {30'd0, idx};
                htrans_n = HTRANS_NONSEQ;
                hwrite_n = 1'b1;
                wdata_n  = key_r[~idx];
                if (bus.HREADY) begin
                    idx_n = idx + 2'd1;
                    if (idx == 2'd3) state_n = COMMIT_KEY;
                end
            end
            COMMIT_KEY: begin
                haddr_n  = ADDR_COMMIT + 32'd1;
                htrans_n = HTRANS_NONSEQ;
                hwrite_n = 1'b1;
                if (bus.HREADY) state_n = WR_CTRL;
            end
            WR_CTRL: begin
                haddr_n  = ADDR_CTRL + {30'd0, idx};
                htrans_n = HTRANS_NONSEQ;
                hwrite_n = 1'b1;
                wdata_n  = (idx == 2'd0) ? 32'd1 : {31'd0, mode_r};
                if (bus.HREADY) begin
                    if (idx == 2'd1) begin
                        idx_n   = '0;
                        state_n = COMMIT_CTRL;
                    end else begin
                        idx_n = idx + 2'd1;
                    end
                end
            end
            COMMIT_CTRL: begin
                haddr_n  = ADDR_COMMIT + 32'd2;
                htrans_n = HTRANS_NONSEQ;
                hwrite_n = 1'b1;
                if (bus.HREADY) begin
                    state_n = WAIT;
                    cnt_n   = '0;
                end
            end
            WAIT: begin
                if (bus.HREADY) begin
                    if (cnt == WAIT_LAST) begin
                        state_n = RD;
                        cnt_n   = '0;
                        idx_n   = '0;
                    end else begin
                        cnt_n = cnt + 8'd1;
                    end
                end
            end
            RD: begin
                haddr_n  = ADDR_DATA + {30'd0, idx};
                htrans_n = HTRANS_NONSEQ;
                if (bus.HREADY) begin
                    idx_n = idx + 2'd1;
                    if (idx == 2'd3) state_n = DONE;
                end
            end
            DONE: begin
                if (bus.HREADY) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Job latches, lagged write data, read capture and result handoff.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            data_r       <= '0;
            key_r        <= '0;
            mode_r       <= 1'b0;
            busy         <= 1'b0;
            hwdata_r     <= '0;
            rd_dp        <= 1'b0;
            rd_word      <= '0;
            shadow       <= '0;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            if (accept) begin
                data_r <= data_in;
                key_r  <= key_in;
                mode_r <= encrypt_mode;
                busy   <= 1'b1;
            end else if (result_valid) begin
                busy <= 1'b0;
            end
            if (bus.HREADY) begin
                hwdata_r <= wdata_n;
                rd_dp    <= (state == RD);
                rd_word  <= idx;
                if (rd_dp) shadow[~rd_word] <= bus.HRDATA;
                if (state == DONE) begin
                    result       <= {shadow[3:1], bus.HRDATA};
                    result_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_aes_ahb_initiator.sv
// Scoreboard bench for aes_ahb_initiator with a behavioural AHB slave.
// Expected transfers/results are queued at start; a monitor checks them.
module tb_aes_ahb_initiator;

    typedef struct packed {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] data;
    } xfer_t;

    logic         tb_HCLK = 1'b0;
    logic         HRESET;
    logic         start;
    logic [127:0] data_in;
    logic [127:0] key_in;
    logic         encrypt_mode;
    logic         busy;
    logic [127:0] result;
    logic         result_valid;

    aes_ahb_initiator_if bus();

    aes_ahb_initiator dut (
        .HCLK         (tb_HCLK),
        .HRESET       (HRESET),
        .start        (start),
        .data_in      (data_in),
        .key_in       (key_in),
        .encrypt_mode (encrypt_mode),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid),
        .bus          (bus.master)
    );

    always #5 tb_HCLK = ~tb_HCLK;

    int           errors = 0;
    int           checks = 0;
    int           cyc = 0;
    int           rv_count = 0;
    xfer_t        exp_q[$];
    logic [127:0] res_q[$];
    xfer_t        pend;
    bit           pend_v = 1'b0;
    logic [31:0]  rdv[4];
    logic         dp_rd;
    logic [1:0]   dp_idx;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Cycle counter used for latency measurement.
    always @(posedge tb_HCLK) cyc <= cyc + 1;

    // Slave read-data model: returns rdv[word] in a read data phase.
    always @(posedge tb_HCLK or posedge HRESET) begin
        if (HRESET) begin
            dp_rd  <= 1'b0;
            dp_idx <= 2'd0;
        end else if (bus.HREADY) begin
            dp_rd  <= (bus.HTRANS == 2'b10) && !bus.HWRITE;
            dp_idx <= 2'(bus.HADDR - 32'd100);
        end
    end

    always_comb bus.HRDATA = dp_rd ? rdv[dp_idx] : 32'h0;

    // Monitor: bus transfers against the expected queue, results on pulse.
    always @(negedge tb_HCLK) begin
        if (HRESET) begin
            pend_v = 1'b0;
        end else begin
            if (bus.HREADY) begin
                if (pend_v && pend.wr)
                    chk($sformatf("hwdata@%0d", pend.addr), bus.HWDATA, pend.data);
                else
                    chk("hwdata_idle", bus.HWDATA, 0);
                pend_v = 1'b0;
                if (bus.HTRANS == 2'b10) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_xfer: got addr %0d expected none",
                                 bus.HADDR);
                    end else begin
                        pend = exp_q.pop_front();
                        chk("haddr", bus.HADDR, pend.addr);
                        chk($sformatf("hwrite@%0d", pend.addr), bus.HWRITE, pend.wr);
                        pend_v = 1'b1;
                    end
                end else begin
                    chk("htrans_idle", bus.HTRANS, 0);
                end
            end
            if (result_valid) begin
                rv_count++;
                if (res_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got %0h expected none", result);
                end else begin
                    chk("result", result, res_q.pop_front());
                end
            end
        end
    end

    task automatic start_job(input logic [127:0] d, input logic [127:0] k,
                             input logic m, output int c0);
        for (int i = 0; i < 4; i++)
            exp_q.push_back('{32'd100 + 32'(i), 1'b1, d[127 - 32*i -: 32]});
        exp_q.push_back('{32'd401, 1'b1, 32'd0});
        for (int i = 0; i < 4; i++)
            exp_q.push_back('{32'd200 + 32'(i), 1'b1, k[127 - 32*i -: 32]});
        exp_q.push_back('{32'd402, 1'b1, 32'd0});
        exp_q.push_back('{32'd301, 1'b1, 32'd1});
        exp_q.push_back('{32'd302, 1'b1, {31'd0, m}});
        exp_q.push_back('{32'd403, 1'b1, 32'd0});
        for (int i = 0; i < 4; i++)
            exp_q.push_back('{32'd100 + 32'(i), 1'b0, 32'd0});
        res_q.push_back({rdv[0], rdv[1], rdv[2], rdv[3]});
        @(posedge tb_HCLK);
        #1;
        bus.HREADY   = 1'b1;
        start        = 1'b1;
        data_in      = d;
        key_in       = k;
        encrypt_mode = m;
        @(posedge tb_HCLK);
        #1;
        c0           = cyc;
        start        = 1'b0;
        data_in      = ~d;
        key_in       = ~k;
        encrypt_mode = ~m;
        chk("busy_after_start", busy, 1);
    endtask

    task automatic wait_done(input int c0, input bit rnd, input bit mid,
                             input bit rvs, input int exp_lat);
        bit seen = 1'b0;
        int lat;
        for (int n = 0; n < 600 && !seen; n++) begin
            @(negedge tb_HCLK);
            if (result_valid) begin
                seen = 1'b1;
            end else begin
                @(posedge tb_HCLK);
                #1;
                bus.HREADY = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
                start      = mid && (n == 5);
            end
        end
        start      = 1'b0;
        bus.HREADY = 1'b1;
        if (!seen) begin
            chk("done_timeout", 0, 1);
        end else begin
            lat = cyc - c0 + 1;
            if (exp_lat > 0) chk("latency", lat, exp_lat);
            chk("busy_on_rv", busy, 1);
            if (rvs) start = 1'b1;
            @(posedge tb_HCLK);
            #1;
            start = 1'b0;
            chk("busy_after_rv", busy, 0);
            repeat (4) @(posedge tb_HCLK);
            #1;
            chk("idle_after_job", busy, 0);
        end
    endtask

    int           c0;
    int           jobs;
    bit           found;
    logic [127:0] k2;

    initial begin
        HRESET       = 1'b1;
        start        = 1'b0;
        data_in      = '0;
        key_in       = '0;
        encrypt_mode = 1'b0;
        bus.HREADY   = 1'b1;
        jobs         = 0;
        for (int i = 0; i < 4; i++) rdv[i] = '0;
        repeat (2) @(posedge tb_HCLK);
        #1;
        chk("rst_haddr", bus.HADDR, 0);
        chk("rst_hwdata", bus.HWDATA, 0);
        chk("rst_hwrite", bus.HWRITE, 0);
        chk("rst_htrans", bus.HTRANS, 0);
        chk("rst_hsize", bus.HSIZE, 3'b010);
        chk("rst_hburst", bus.HBURST, 0);
        chk("rst_busy", busy, 0);
        chk("rst_result", result, 0);
        chk("rst_rv", result_valid, 0);
        HRESET = 1'b0;

        // Reference job, with a stray start pulse mid-job.
        rdv = '{32'h22222222, 32'h33333333, 32'h55555555, 32'h44444444};
        start_job(128'h12121212_34343434_56565656_12345676,
                  128'h11111111_44444444_99999999_12345676, 1'b1, c0);
        wait_done(c0, 1'b0, 1'b1, 1'b0, 39);
        jobs++;

        // Decrypt job with a 3-cycle stall in the 202 data phase.
        rdv = '{32'hA0A0A0A1, 32'hB0B0B0B2, 32'hC0C0C0C3, 32'hD0D0D0D4};
        k2  = 128'hCAFEF00D_DEADBEEF_0BADC0DE_FEEDFACE;
        start_job(128'h01234567_89ABCDEF_FEDCBA98_76543210, k2, 1'b0, c0);
        found = 1'b0;
        for (int n = 0; n < 50 && !found; n++) begin
            @(negedge tb_HCLK);
            found = (bus.HADDR == 32'd202) && (bus.HTRANS == 2'b10);
        end
        chk("found_202", found, 1);
        @(posedge tb_HCLK);
        #1;
        bus.HREADY = 1'b0;
        repeat (3) begin
            @(negedge tb_HCLK);
            chk("stall_haddr", bus.HADDR, 203);
            chk("stall_hwdata", bus.HWDATA, k2[63:32]);
            @(posedge tb_HCLK);
        end
        #1;
        bus.HREADY = 1'b1;
        wait_done(c0, 1'b0, 1'b0, 1'b1, 42);
        jobs++;

        // Reset in the middle of the key writes.
        start_job(128'h55555555_66666666_77777777_88888888,
                  128'h99999999_AAAAAAAA_BBBBBBBB_CCCCCCCC, 1'b1, c0);
        found = 1'b0;
        for (int n = 0; n < 50 && !found; n++) begin
            @(negedge tb_HCLK);
            found = (bus.HADDR == 32'd201);
        end
        chk("found_201", found, 1);
        #2;
        HRESET = 1'b1;
        #1;
        chk("mid_rst_haddr", bus.HADDR, 0);
        chk("mid_rst_hwdata", bus.HWDATA, 0);
        chk("mid_rst_hwrite", bus.HWRITE, 0);
        chk("mid_rst_htrans", bus.HTRANS, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_result", result, 0);
        exp_q.delete();
        res_q.delete();
        @(posedge tb_HCLK);
        @(posedge tb_HCLK);
        #1;
        HRESET = 1'b0;

        rdv = '{32'h01010101, 32'h02020202, 32'h03030303, 32'h04040404};
        start_job(128'hFFEEDDCC_BBAA9988_77665544_33221100,
                  128'h0F0E0D0C_0B0A0908_07060504_03020100, 1'b1, c0);
        wait_done(c0, 1'b0, 1'b0, 1'b0, 39);
        jobs++;

        // Random jobs with random HREADY wait states.
        for (int j = 0; j < 6; j++) begin
            for (int i = 0; i < 4; i++) rdv[i] = $urandom;
            start_job({$urandom, $urandom, $urandom, $urandom},
                      {$urandom, $urandom, $urandom, $urandom},
                      1'($urandom_range(0, 1)), c0);
            wait_done(c0, 1'b1, 1'b0, 1'b0, 0);
            jobs++;
        end

        repeat (5) @(posedge tb_HCLK);
        #1;
        chk("exp_q_empty", exp_q.size(), 0);
        chk("res_q_empty", res_q.size(), 0);
        chk("rv_count", rv_count, jobs);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
